// File: rtl/psdifir_pkg.sv
// Shared constants and types for the psdifir audio path (filter core and I2S output).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psdifir_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int SLOT_W    = 32;
  localparam int BCLK_HDIV = 16;

  localparam int POS_W = $clog2(SLOT_W);
  localparam int IDX_W = $clog2(SAMPLE_W);
  localparam int BI_W  = $clog2(2 * SLOT_W);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  // Serial bit for slot position pos: pos 0 is the I2S delay bit, then MSB first,
  // then zero padding to the end of the slot.
  function automatic logic slot_bit(input sample_t smp, input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] bi;
    bi = POS_W'(SAMPLE_W) - pos;
    if (pos != '0 && pos <= POS_W'(SAMPLE_W)) return smp[bi[IDX_W-1:0]];
    return 1'b0;
  endfunction

endpackage

// File: rtl/psdifir_clkdiv.sv
// Bit clock generator: divides the master clock to bclk and flags each bclk falling edge.
// Latency: bclk toggles on the cycle div_cnt hits terminal count; fall_evt_o is combinational with it.
// Backpressure: none, free running.
module psdifir_clkdiv
  import psdifir_pkg::*;
#(
  parameter int HDIV = BCLK_HDIV
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic bclk_o,
  output logic fall_evt_o
);

  localparam int CW = $clog2(HDIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          tc;

  // Half-period counter and bclk toggle at terminal count.
  always_comb begin
    tc        = (div_cnt_q == CW'(HDIV - 1));
    div_cnt_d = tc ? '0 : div_cnt_q + CW'(1);
    bclk_d    = tc ? ~bclk_q : bclk_q;
  end

  // Divider state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign fall_evt_o = tc & bclk_q;

endmodule

// File: rtl/psdifir_i2s_tx.sv
// I2S transmitter: serialises parallel stereo samples to a DAC, one frame per 2*SLOT_W bclks.
// Latency: a sample pending at a frame load drives its MSB one bclk fall after that load (pos 1).
// Backpressure: none; sample_req paces the source, overrun/underrun record pacing violations.
module psdifir_i2s_tx
  import psdifir_pkg::*;
(
  input  logic                clockext100MHz,
  input  logic                reset,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                sample_req,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                overrun,
  output logic                underrun
);

  logic fall_evt;

  psdifir_clkdiv #(.HDIV(BCLK_HDIV)) u_clkdiv (
    .clk_i      (clockext100MHz),
    .rst_i      (reset),
    .bclk_o     (bclk),
    .fall_evt_o (fall_evt)
  );

  logic [BI_W-1:0] bit_idx_q, bit_idx_d;
  logic            lrclk_q, lrclk_d;
  logic            sdata_q, sdata_d;
  logic            req_q, req_d;
  logic            ovr_q, ovr_d;
  logic            und_q, und_d;
  stereo_t         pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  stereo_t         frame_q, frame_d;
  logic            load;
  logic [BI_W-1:0] pos_full;

  // Next-state: bit position, serial outputs, sample capture, frame load and flags.
  always_comb begin
    bit_idx_d  = bit_idx_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    ovr_d      = ovr_q;
    und_d      = und_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    frame_d    = frame_q;
    pos_full   = '0;

    load  = fall_evt && (bit_idx_q == BI_W'(2 * SLOT_W - 1));
    req_d = load;

    if (fall_evt) begin
      bit_idx_d = load ? '0 : bit_idx_q + BI_W'(1);
      lrclk_d   = (bit_idx_d >= BI_W'(SLOT_W));
      pos_full  = lrclk_d ? bit_idx_d - BI_W'(SLOT_W) : bit_idx_d;
      // At a load the new position is 0, so the old frame value is never shown.
      sdata_d   = slot_bit(lrclk_d ? frame_q.r : frame_q.l, pos_full[POS_W-1:0]);
    end

    if (load) begin
      pend_vld_d = 1'b0;
      if (pend_vld_q) frame_d = pend_q;
      else            und_d   = 1'b1;
    end

    // A strobe on the load cycle refills pending after the load took the old value.
    if (sample_ready) begin
      pend_d     = '{l: left_in, r: right_in};
      pend_vld_d = 1'b1;
      if (pend_vld_q && !load) ovr_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clockext100MHz) begin
    if (reset) begin
      bit_idx_q  <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      req_q      <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      req_q      <= req_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      frame_q    <= frame_d;
    end
  end

  assign sample_req = req_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign overrun    = ovr_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_psdifir_i2s_tx.sv
// Bench for psdifir_i2s_tx: cycle-level frame model plus deserialised slot-word checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_psdifir_i2s_tx;

  localparam int HALF  = 16;
  localparam int BITT  = 32;
  localparam int FRAME = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_ready = 1'b0;
  logic [17:0] left_in = '0;
  logic [17:0] right_in = '0;
  logic        sample_req, bclk, lrclk, sdata, overrun, underrun;

  always #5 clk = ~clk;

  psdifir_i2s_tx dut (
    .clockext100MHz (clk),
    .reset          (reset),
    .sample_ready   (sample_ready),
    .left_in        (left_in),
    .right_in       (right_in),
    .sample_req     (sample_req),
    .bclk           (bclk),
    .lrclk          (lrclk),
    .sdata          (sdata),
    .overrun        (overrun),
    .underrun       (underrun)
  );

  int n_chk = 0;
  int n_pass = 0;
  int t = 0;

  // Model state: pending/frame samples and sticky flags.
  logic [17:0] m_pl, m_pr, m_fl, m_fr;
  logic        m_pv, m_ovr, m_und;

  // Deserialiser state.
  logic        prev_bclk;
  int          k;
  logic [31:0] wl, wr;
  logic [31:0] q_l[$];
  logic [31:0] q_r[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
  endtask

  function automatic logic [31:0] ql(input int i);
    if (i < q_l.size()) return q_l[i];
    return 'x;
  endfunction

  function automatic logic [31:0] qr(input int i);
    if (i < q_r.size()) return q_r[i];
    return 'x;
  endfunction

  // Model update, per-cycle compare and slot deserialiser.
  initial begin
    int          idx, pos;
    logic        ld, e_bclk, e_lr, e_sd, e_req;
    logic [17:0] smp;
    logic [5:0]  act_v, exp_v;
    m_pl = '0; m_pr = '0; m_fl = '0; m_fr = '0;
    m_pv = 1'b0; m_ovr = 1'b0; m_und = 1'b0;
    prev_bclk = 1'b0; k = 0; wl = '0; wr = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        t = 0;
        m_pl = '0; m_pr = '0; m_fl = '0; m_fr = '0;
        m_pv = 1'b0; m_ovr = 1'b0; m_und = 1'b0;
        k = 0; wl = '0; wr = '0;
        q_l.delete(); q_r.delete();
      end else begin
        t++;
        ld = (t % FRAME == 0);
        if (ld) begin
          if (m_pv) begin m_fl = m_pl; m_fr = m_pr; end
          else m_und = 1'b1;
        end
        if (sample_ready) begin
          if (m_pv && !ld) m_ovr = 1'b1;
          m_pl = left_in; m_pr = right_in;
        end
        if (ld) m_pv = 1'b0;
        if (sample_ready) m_pv = 1'b1;
      end
      #1;
      idx    = (t / BITT) % 64;
      pos    = idx % 32;
      e_lr   = (idx >= 32);
      e_bclk = ((t / HALF) % 2) == 1;
      smp    = e_lr ? m_fr : m_fl;
      smp    = smp >> (18 - pos);
      e_sd   = (pos >= 1 && pos <= 18) ? smp[0] : 1'b0;
      e_req  = (t > 0) && (t % FRAME == 0);
      act_v  = {bclk, lrclk, sdata, sample_req, overrun, underrun};
      exp_v  = {e_bclk, e_lr, e_sd, e_req, m_ovr, m_und};
      check("cycle{bclk,lrclk,sdata,req,ovr,und}", 32'(act_v), 32'(exp_v));
      if (!prev_bclk && bclk) begin
        if ((k % 64) < 32) wl = {wl[30:0], sdata};
        else               wr = {wr[30:0], sdata};
        if ((k % 64) == 63) begin q_l.push_back(wl); q_r.push_back(wr); end
        k++;
      end
      prev_bclk = bclk;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_t(input int target);
    int guard = 0;
    while (t < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (t < target) check("wait_t_timeout", 32'(t), 32'(target));
  endtask

  task automatic wait_req();
    int guard = 0;
    while (sample_req !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (sample_req !== 1'b1) check("wait_req_timeout", 32'(sample_req), 32'd1);
  endtask

  task automatic strobe(input logic [17:0] l, input logic [17:0] r);
    sample_ready = 1'b1;
    left_in = l;
    right_in = r;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  initial begin
    // 1) Reset and idle.
    do_reset();
    check("reset_outputs", 32'({bclk, lrclk, sdata, sample_req, overrun, underrun}), 32'd0);
    wait_req();
    check("t1_first_req_time", 32'(t), 32'd2048);
    wait_t(2060);
    check("t1_underrun", 32'(underrun), 32'd1);
    check("t1_overrun", 32'(overrun), 32'd0);
    wait_t(4100);
    check("t1_frame1_left", ql(1), 32'h0);
    check("t1_frame1_right", qr(1), 32'h0);

    // 2) Alternating patterns, fed on every request.
    do_reset();
    strobe(18'h2AAAA, 18'h15555);
    wait_req();
    strobe(18'h2AAAA, 18'h15555);
    wait_t(6135);
    check("t2_frame1_left", ql(1), 32'h55554000);
    check("t2_frame1_right", qr(1), 32'h2AAAA000);
    check("t2_frame2_left", ql(2), 32'h55554000);
    check("t2_frame2_right", qr(2), 32'h2AAAA000);
    check("t2_overrun", 32'(overrun), 32'd0);
    check("t2_underrun", 32'(underrun), 32'd0);

    // 3) Two strobes in one frame: overrun, newest wins.
    do_reset();
    strobe(18'h00001, 18'h00001);
    wait_t(100);
    strobe(18'h3FFFF, 18'h3FFFF);
    check("t3_overrun", 32'(overrun), 32'd1);
    wait_t(4090);
    check("t3_frame1_left", ql(1), 32'h7FFFE000);
    check("t3_frame1_right", qr(1), 32'h7FFFE000);
    check("t3_underrun", 32'(underrun), 32'd0);

    // 4) Strobe on the exact load cycle.
    do_reset();
    strobe(18'h0F0F0, 18'h0F0F0);
    wait_t(2047);
    strobe(18'h3C3C3, 18'h3C3C3);
    wait_t(6135);
    check("t4_frame1_left", ql(1), 32'h1E1E0000);
    check("t4_frame2_left", ql(2), 32'h78786000);
    check("t4_frame2_right", qr(2), 32'h78786000);
    check("t4_overrun", 32'(overrun), 32'd0);
    check("t4_underrun", 32'(underrun), 32'd0);

    // 5) Single sample then hold-off: repeated frame and underrun.
    do_reset();
    strobe(18'h12345, 18'h12345);
    wait_t(6135);
    check("t5_frame1_left", ql(1), 32'h2468A000);
    check("t5_frame2_left", ql(2), 32'h2468A000);
    check("t5_frame2_right", qr(2), 32'h2468A000);
    check("t5_underrun", 32'(underrun), 32'd1);

    // 6) Reset in the middle of the right slot (bit_idx 40).
    wait_t(3 * FRAME + 40 * BITT + 8);
    check("t6_pre_reset_lrclk", 32'(lrclk), 32'd1);
    do_reset();
    check("t6_post_reset_outputs", 32'({bclk, lrclk, sdata, sample_req, overrun, underrun}), 32'd0);
    wait_t(40);
    check("t6_restart_lrclk", 32'(lrclk), 32'd0);
    wait_t(2100);
    check("t6_frame0_left", ql(0), 32'h0);
    check("t6_underrun", 32'(underrun), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
